// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Forwarding selects, MDU FSM states, widths.
package pipe_ctrl_pkg;

  localparam int RA_W  = 5;
  localparam int CNT_W = 8;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMDAT = 2'b11;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // EX ALU result wins; an EX load has no data yet, so fall to MEM.
  function automatic logic [1:0] fwd_sel(
    input logic exhit,
    input logic ex_ld,
    input logic memhit,
    input logic mem_ld
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (exhit && !ex_ld)
      sel = FWD_EXALU;
    else if (memhit && !mem_ld)
      sel = FWD_MEMALU;
    else if (memhit && mem_ld)
      sel = FWD_MEMDAT;
    return sel;
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// MDU busy sequencer: accepts start, counts MDU_LAT-1 busy cycles.
// Ports: clk, clrn, start, load_use -> mdu_go, mdu_busy, mdu_done.
module mdu_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 8
) (
  input  logic clk,
  input  logic clrn,
  input  logic start,
  input  logic load_use,
  output logic mdu_go,
  output logic mdu_busy,
  output logic mdu_done
);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;

  assign mdu_busy = (state == MDU_BUSY);
  assign mdu_go   = (state == MDU_IDLE)
                  & start & ~load_use;
  assign mdu_done = mdu_busy
                  & (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        MDU_IDLE: begin
          if (mdu_go) begin
            cnt   <= CNT_W'(MDU_LAT - 1);
            state <= MDU_BUSY;
          end
        end
        MDU_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (mdu_done)
            state <= MDU_IDLE;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control: stalls, flushes, bubbles, ID forwarding.
// Ports: ID decode + imem_ready in; pc/ifid/idex ctl, fwda/b, mdu out.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 8,
  parameter int RA_W    = pipe_ctrl_pkg::RA_W
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_wreg,
  input  logic            id_m2reg,
  input  logic            id_branch_taken,
  input  logic            id_mdu_start,
  input  logic            id_mdu_use,
  input  logic            imem_ready,
  output logic            pc_stall,
  output logic            ifid_stall,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic [1:0]      fwda,
  output logic [1:0]      fwdb,
  output logic            mdu_go,
  output logic            mdu_busy
);

  import pipe_ctrl_pkg::*;

  logic [RA_W-1:0] ex_rd;
  logic [RA_W-1:0] mem_rd;
  logic ex_wreg, ex_m2reg;
  logic mem_wreg, mem_m2reg;

  logic ex_ok, mem_ok;
  logic exhit_rs, exhit_rt;
  logic memhit_rs, memhit_rt;
  logic load_use, mdu_stall, id_stall;
  logic mdu_done;

  // r0 is hardwired, so a write to it is never a producer.
  assign ex_ok  = ex_wreg & (ex_rd != '0);
  assign mem_ok = mem_wreg & (mem_rd != '0);

  assign exhit_rs  = ex_ok & (ex_rd == id_rs);
  assign exhit_rt  = ex_ok & (ex_rd == id_rt);
  assign memhit_rs = mem_ok & (mem_rd == id_rs);
  assign memhit_rt = mem_ok & (mem_rd == id_rt);

  assign fwda = fwd_sel(exhit_rs, ex_m2reg,
                        memhit_rs, mem_m2reg);
  assign fwdb = fwd_sel(exhit_rt, ex_m2reg,
                        memhit_rt, mem_m2reg);

  assign load_use = ((id_use_rs & exhit_rs)
                   | (id_use_rt & exhit_rt))
                   & ex_m2reg;

  assign mdu_stall = mdu_busy
                   & (id_mdu_start | id_mdu_use);
  assign id_stall  = load_use | mdu_stall;

  // A stall freezes the front end and ignores a branch
  // decided on stale operands.
  assign ifid_stall  = id_stall;
  assign idex_bubble = id_stall;
  assign pc_stall    = id_stall
                     | (~id_branch_taken & ~imem_ready);
  assign ifid_flush  = ~id_stall
                     & (id_branch_taken | ~imem_ready);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ex_rd     <= '0;
      ex_wreg   <= 1'b0;
      ex_m2reg  <= 1'b0;
      mem_rd    <= '0;
      mem_wreg  <= 1'b0;
      mem_m2reg <= 1'b0;
    end else begin
      ex_rd     <= idex_bubble ? '0 : id_rd;
      ex_wreg   <= idex_bubble ? 1'b0 : id_wreg;
      ex_m2reg  <= idex_bubble ? 1'b0 : id_m2reg;
      mem_rd    <= ex_rd;
      mem_wreg  <= ex_wreg;
      mem_m2reg <= ex_m2reg;
    end
  end

  mdu_seq #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu (
    .clk      (clk),
    .clrn     (clrn),
    .start    (id_mdu_start),
    .load_use (load_use),
    .mdu_go   (mdu_go),
    .mdu_busy (mdu_busy),
    .mdu_done (mdu_done)
  );

  // The done pulse always ends the busy window.
  a_done_idle: assert property (
    @(posedge clk) disable iff (!clrn)
    mdu_done |=> !mdu_busy
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// Directed scenarios plus random traffic against a pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 8;
  localparam int RW  = 5;

  logic          clk = 1'b0;
  logic          clrn;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic id_use_rs, id_use_rt, id_wreg, id_m2reg;
  logic id_branch_taken, id_mdu_start, id_mdu_use;
  logic imem_ready;
  logic pc_stall, ifid_stall, ifid_flush, idex_bubble;
  logic [1:0] fwda, fwdb;
  logic mdu_go, mdu_busy;
  logic [9:0] dut_out;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MDU_LAT (LAT),
    .RA_W    (RW)
  ) dut (
    .clk             (clk),
    .clrn            (clrn),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_rd           (id_rd),
    .id_wreg         (id_wreg),
    .id_m2reg        (id_m2reg),
    .id_branch_taken (id_branch_taken),
    .id_mdu_start    (id_mdu_start),
    .id_mdu_use      (id_mdu_use),
    .imem_ready      (imem_ready),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .fwda            (fwda),
    .fwdb            (fwdb),
    .mdu_go          (mdu_go),
    .mdu_busy        (mdu_busy)
  );

  assign dut_out = {pc_stall, ifid_stall, ifid_flush,
                    idex_bubble, fwda, fwdb,
                    mdu_go, mdu_busy};

  // Model: in-flight writers, youngest first (0=EX, 1=MEM),
  // plus cycles of MDU occupancy left.
  typedef struct {
    int rd;
    bit wreg;
    bit m2reg;
  } wr_t;

  wr_t pipe[2];
  int  busy_left;
  int  n_tests = 0;
  int  n_fail  = 0;

  function automatic logic [1:0] m_fwd(int r);
    if (r == 0) return 2'b00;
    for (int s = 0; s < 2; s++) begin
      if (pipe[s].wreg && pipe[s].rd == r) begin
        if (s == 0 && !pipe[s].m2reg) return 2'b01;
        if (s == 1) return pipe[s].m2reg ? 2'b11 : 2'b10;
      end
    end
    return 2'b00;
  endfunction

  function automatic bit m_waits_load(int r);
    return r != 0 && pipe[0].wreg && pipe[0].m2reg
        && pipe[0].rd == r;
  endfunction

  function automatic bit m_load_use();
    return (id_use_rs && m_waits_load(int'(id_rs)))
        || (id_use_rt && m_waits_load(int'(id_rt)));
  endfunction

  function automatic bit m_stall();
    return m_load_use()
        || (busy_left > 0 && (id_mdu_start || id_mdu_use));
  endfunction

  function automatic logic [9:0] m_out();
    bit st, br, im, go;
    st = m_stall();
    br = id_branch_taken;
    im = imem_ready;
    go = busy_left == 0 && id_mdu_start && !m_load_use();
    return {st | (!br & !im), st, !st & (br | !im), st,
            m_fwd(int'(id_rs)), m_fwd(int'(id_rt)),
            go, busy_left > 0};
  endfunction

  task automatic m_clear();
    pipe[0] = '{0, 1'b0, 1'b0};
    pipe[1] = '{0, 1'b0, 1'b0};
    busy_left = 0;
  endtask

  task automatic m_adv();
    bit st, go;
    if (!clrn) begin
      m_clear();
      return;
    end
    st = m_stall();
    go = busy_left == 0 && id_mdu_start && !m_load_use();
    pipe[1] = pipe[0];
    if (st) pipe[0] = '{0, 1'b0, 1'b0};
    else    pipe[0] = '{int'(id_rd), id_wreg, id_m2reg};
    if (busy_left > 0) busy_left--;
    else if (go)       busy_left = LAT - 1;
  endtask

  task automatic step();
    @(posedge clk);
    m_adv();
    #1;
  endtask

  task automatic set_id(input int rs, input int rt,
                        input bit urs, input bit urt,
                        input int rd, input bit wr,
                        input bit ld, input bit br,
                        input bit st, input bit us,
                        input bit im);
    id_rs = RW'(rs);
    id_rt = RW'(rt);
    id_use_rs = urs;
    id_use_rt = urt;
    id_rd = RW'(rd);
    id_wreg = wr;
    id_m2reg = ld;
    id_branch_taken = br;
    id_mdu_start = st;
    id_mdu_use = us;
    imem_ready = im;
  endtask

  task automatic idle_in();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic drain();
    idle_in();
    for (int i = 0; i < 3 * LAT && busy_left > 0; i++)
      step();
    step();
    step();
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_clear();
    @(negedge clk);
    n_tests++;
    if (dut_out !== 10'b1010_0000_00) begin
      n_fail++;
      $display("FAIL reset_imem_wait: got %b want %b",
               dut_out, 10'b1010_0000_00);
    end
    imem_ready = 1'b1;
    #1;
    n_tests++;
    if (dut_out !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_quiet: got %b want %b",
               dut_out, 10'b0);
    end
    @(negedge clk);
    clrn = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    drain();
    set_id(0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 1);
    step();
    set_id(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    n_tests++;
    if ({pc_stall, ifid_stall, idex_bubble, ifid_flush}
        !== 4'b1110) begin
      n_fail++;
      $display("FAIL load_use_stall: got %b want 1110",
               {pc_stall, ifid_stall, idex_bubble, ifid_flush});
    end
    step();
    @(negedge clk);
    n_tests++;
    if ({fwda, pc_stall, idex_bubble} !== 4'b1100) begin
      n_fail++;
      $display("FAIL load_use_fwd: got %b want 1100",
               {fwda, pc_stall, idex_bubble});
    end
    step();
  endtask

  task automatic test_fwd_priority();
    drain();
    set_id(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1);
    step();
    step();
    set_id(0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    n_tests++;
    if ({fwdb, pc_stall} !== 3'b010) begin
      n_fail++;
      $display("FAIL fwd_ex_prio: got %b want 010",
               {fwdb, pc_stall});
    end
    step();
    set_id(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    step();
    step();
    set_id(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    n_tests++;
    if ({fwdb, pc_stall, idex_bubble} !== 4'b0000) begin
      n_fail++;
      $display("FAIL fwd_r0: got %b want 0000",
               {fwdb, pc_stall, idex_bubble});
    end
    step();
  endtask

  task automatic test_branch();
    drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    @(negedge clk);
    n_tests++;
    if ({ifid_flush, pc_stall, ifid_stall} !== 3'b100) begin
      n_fail++;
      $display("FAIL branch_flush: got %b want 100",
               {ifid_flush, pc_stall, ifid_stall});
    end
    step();
    set_id(0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 1);
    step();
    set_id(7, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if ({ifid_flush, pc_stall, idex_bubble} !== 3'b011) begin
      n_fail++;
      $display("FAIL branch_vs_load_use: got %b want 011",
               {ifid_flush, pc_stall, idex_bubble});
    end
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if ({ifid_flush, pc_stall} !== 2'b10) begin
      n_fail++;
      $display("FAIL branch_vs_imem: got %b want 10",
               {ifid_flush, pc_stall});
    end
    step();
  endtask

  task automatic test_imem_wait();
    int hits;
    drain();
    hits = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({pc_stall, ifid_flush, idex_bubble} === 3'b110)
        hits++;
      step();
    end
    n_tests++;
    if (hits != 3) begin
      n_fail++;
      $display("FAIL imem_wait: got %0d cycles want 3", hits);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({pc_stall, ifid_flush} !== 2'b00) begin
      n_fail++;
      $display("FAIL imem_resume: got %b want 00",
               {pc_stall, ifid_flush});
    end
    step();
  endtask

  task automatic test_mdu();
    int stalls, busy_cnt;
    bit issued;
    drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    @(negedge clk);
    n_tests++;
    if ({mdu_go, mdu_busy, pc_stall} !== 3'b100) begin
      n_fail++;
      $display("FAIL mdu_go: got %b want 100",
               {mdu_go, mdu_busy, pc_stall});
    end
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    stalls = 0;
    busy_cnt = 0;
    issued = 0;
    for (int i = 0; i < 20 && !issued; i++) begin
      @(negedge clk);
      if (mdu_busy === 1'b1) busy_cnt++;
      if (pc_stall === 1'b1) stalls++;
      else issued = 1;
      step();
    end
    n_tests++;
    if (!issued || stalls != LAT - 1 || busy_cnt != LAT - 1)
    begin
      n_fail++;
      $display("FAIL mdu_mfhi: stalls %0d busy %0d want %0d",
               stalls, busy_cnt, LAT - 1);
    end
    drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step();
    stalls = 0;
    issued = 0;
    for (int i = 0; i < 20 && !issued; i++) begin
      @(negedge clk);
      if (mdu_go === 1'b1) issued = 1;
      else if (pc_stall === 1'b1) stalls++;
      step();
    end
    n_tests++;
    if (!issued || stalls != LAT - 1) begin
      n_fail++;
      $display("FAIL mdu_b2b: stalls %0d want %0d",
               stalls, LAT - 1);
    end
    drain();
  endtask

  task automatic test_reset_mid_busy();
    drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step();
    set_id(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1);
    step();
    set_id(5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    #2;
    n_tests++;
    if ({mdu_busy, fwda, fwdb} !== 5'b10101) begin
      n_fail++;
      $display("FAIL pre_reset: got %b want 10101",
               {mdu_busy, fwda, fwdb});
    end
    clrn = 1'b0;
    m_clear();
    #1;
    n_tests++;
    if ({mdu_busy, fwda, fwdb} !== 5'b00000) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 00000",
               {mdu_busy, fwda, fwdb});
    end
    step();
    @(negedge clk);
    clrn = 1'b1;
    step();
    @(negedge clk);
    n_tests++;
    if (dut_out !== m_out()) begin
      n_fail++;
      $display("FAIL post_reset: got %b want %b",
               dut_out, m_out());
    end
    step();
  endtask

  task automatic test_random();
    int bad;
    logic [9:0] exp;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      set_id($urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 7),
             $urandom_range(0, 2) != 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 6) == 0,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 6) == 0,
             $urandom_range(0, 4) != 0);
      @(negedge clk);
      exp = m_out();
      n_tests++;
      if (dut_out !== exp) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: got %b want %b",
                   i, dut_out, exp);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_branch();
    test_imem_wait();
    test_mdu();
    test_reset_mid_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Drives stall and flush for the PC and the IF/ID register, bubble insertion into ID/EX, and the ID-stage forwarding selects.
- Keeps its own shadow copy of EX/MEM destination info, so it needs only ID-stage decode info plus handshakes.
- Sequences the multi-cycle multiply/divide unit (MDU) with a busy FSM.

Parameters:
- MDU_LAT, 8, MDU cycles from accepted start to result valid (range 2..255).
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- id_rs  in  RA_W  ID source register A.
- id_rt  in  RA_W  ID source register B.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_rd  in  RA_W  ID destination register.
- id_wreg  in  1  ID instruction writes the register file.
- id_m2reg  in  1  ID instruction is a load.
- id_branch_taken  in  1  branch/jump resolved taken in ID.
- id_mdu_start  in  1  ID instruction starts a mul/div.
- id_mdu_use  in  1  ID instruction reads HI/LO (mfhi/mflo).
- imem_ready  in  1  instruction memory returns valid data this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  synchronous clear of IF/ID (inserts a nop).
- idex_bubble  out  1  zero the control fields entering ID/EX.
- fwda  out  2  rs select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data.
- fwdb  out  2  rt select, same encoding.
- mdu_go  out  1  start pulse to the MDU.
- mdu_busy  out  1  MDU FSM not IDLE.

Behaviour:
- Reset:
  - All shadow registers are 0; the FSM is IDLE; the counter is 0.
  - With inputs at 0, every output is 0, except pc_stall=1 and ifid_flush=1 while imem_ready=0.
  - Reset is asynchronous and may arrive mid-MDU operation: the FSM is forced to IDLE and no mdu_done is produced.
- Shadow pipeline, every posedge:
  - ex_{rd,wreg,m2reg} <= id values, or 0 if idex_bubble.
  - mem_* <= ex_*.
  - Shadow registers never stall, because EX/MEM/WB never stall.
- Hit definitions:
  - exhit(r) = ex_wreg & ex_rd!=0 & ex_rd==r.
  - memhit(r) = mem_wreg & mem_rd!=0 & mem_rd==r.
  - Register 0 is never forwarded and never stalls.
- Forwarding (combinational, 0 latency), for fwda over rs; fwdb is identical over rt:
  - 01 if exhit & !ex_m2reg.
  - else 10 if memhit & !mem_m2reg.
  - else 11 if memhit & mem_m2reg.
  - else 00.
  - EX has priority over MEM.
- load_use = (id_use_rs & exhit(rs) | id_use_rt & exhit(rt)) & ex_m2reg.
- mdu_stall = mdu_busy & (id_mdu_start | id_mdu_use).
- id_stall = load_use | mdu_stall.
- Priority:
  - id_stall: pc_stall=1, ifid_stall=1, idex_bubble=1, ifid_flush=0. id_branch_taken is ignored because its operands are stale.
  - else id_branch_taken: ifid_flush=1, no delay slot. pc_stall=0, so the PC loads the target.
  - else imem_ready=0: pc_stall=1, ifid_flush=1. The ID instruction proceeds normally.
  - When branch and imem wait coincide, the PC still loads the target and IF/ID is flushed.
- MDU FSM:
  - IDLE: if id_mdu_start & !load_use, then mdu_go=1 for 1 cycle, cnt <= MDU_LAT-1, go to BUSY.
  - BUSY: cnt decrements each cycle. At cnt==1, mdu_done is pulsed internally and the next state is IDLE.
  - mdu_busy=1 for exactly MDU_LAT-1 cycles after the mdu_go cycle. A dependent instruction issues on the cycle mdu_busy falls.
  - A start arriving in the same cycle as the return to IDLE is stalled that cycle and accepted the next.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - FWD_RF/FWD_EXALU/FWD_MEMALU/FWD_MEMDAT encodings.
  - MDU state encoding (IDLE, BUSY).
  - RA_W constant.
- Sub-module mdu_seq holds the FSM and counter: start/load_use in, mdu_go/mdu_busy/mdu_done out.

Test Plan:
- Load r3 in EX, ID reads rs=3 -> one cycle of pc_stall=ifid_stall=idex_bubble=1. Next cycle fwda=11, stalls clear.
- ALU writes r5 in EX and an older ALU write to r5 is in MEM, ID rt=5 -> fwdb=01 (EX priority). Same with rd=0 -> fwdb=00, no stall.
- id_branch_taken=1, no hazard -> ifid_flush=1, pc_stall=0. Same cycle as load_use -> flush=0, stall=1.
- imem_ready low 3 cycles -> pc_stall=1 and ifid_flush=1 for 3 cycles, idex_bubble=0.
- MDU_LAT=8: start -> mdu_go 1 cycle, mdu_busy 7 cycles. mfhi behind it stalls 7 cycles and issues on cycle 8. Back-to-back start behaves the same.
- clrn pulsed mid-BUSY -> mdu_busy=0 immediately, shadows cleared, fwda=fwdb=00.
